// File: rtl/wb_stage.sv
// wb_stage: writeback stage of the 5-stage pipeline.
// This stage takes the MEM-stage latch directly. It owns the 32-entry
// architectural register file, commits register writes, counts retired
// instructions and tracks the PC of the last retired instruction. A
// RUN/HALTED/ERROR state machine freezes all of that architectural state
// when a halt instruction retires or when a bus-canary mismatch is seen.
//
// Ports:
//   clk             - pipeline clock
//   reset           - asynchronous, active-low reset
//   from_MEM_latch  - {inst, PC, op_I, inst_count, reg_dest, result, wr_reg, bus_canary}
//   rs1_idx/rs2_idx - DE-stage read port indices
//   rs1_val/rs2_val - combinational read data, with same-cycle write bypass
//   from_WB_to_DE   - {commit_wr, reg_dest, result}
//   from_WB_to_AGEX - {commit_wr, reg_dest}
//   retired_count   - number of retired instructions (wraps)
//   last_pc         - PC of the most recently retired instruction
//   halted          - high in the HALTED state
//   canary_err      - high in the ERROR state

`ifndef WB_STAGE_DEFS
`define WB_STAGE_DEFS
`define DBITS 32
`define INSTBITS 32
`define OPBITS 8
`define CANARY_BITS 16
`define BUS_CANARY_VALUE 16'hCAFE
`define MEM_latch_WIDTH (`INSTBITS + `DBITS + `OPBITS + `DBITS + 5 + `DBITS + 1 + `CANARY_BITS)
`define from_WB_to_DE_WIDTH (1 + 5 + `DBITS)
`define from_WB_to_AGEX_WIDTH (1 + 5)
`endif

module wb_stage #(
  parameter logic [`INSTBITS-1:0]    HALT_INST    = 32'h0000_0073,
  parameter logic [`CANARY_BITS-1:0] CANARY_VALUE = `BUS_CANARY_VALUE,
  parameter int unsigned             NUM_REGS     = 32
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [`MEM_latch_WIDTH-1:0]       from_MEM_latch,
  input  logic [4:0]                        rs1_idx,
  input  logic [4:0]                        rs2_idx,
  output logic [`DBITS-1:0]                 rs1_val,
  output logic [`DBITS-1:0]                 rs2_val,
  output logic [`from_WB_to_DE_WIDTH-1:0]   from_WB_to_DE,
  output logic [`from_WB_to_AGEX_WIDTH-1:0] from_WB_to_AGEX,
  output logic [`DBITS-1:0]                 retired_count,
  output logic [`DBITS-1:0]                 last_pc,
  output logic                              halted,
  output logic                              canary_err
);

  typedef enum logic [1:0] {RUN, HALTED, ERROR} state_e;

  // Latch fields
  logic [`INSTBITS-1:0]    inst;
  logic [`DBITS-1:0]       pc;
  logic [`OPBITS-1:0]      op_i;
  logic [`DBITS-1:0]       inst_count;
  logic [4:0]              reg_dest;
  logic [`DBITS-1:0]       result;
  logic                    wr_reg;
  logic [`CANARY_BITS-1:0] bus_canary;

  assign {inst, pc, op_i, inst_count, reg_dest, result, wr_reg, bus_canary} = from_MEM_latch;

  // inst_count travels with the latch for debug only; it is not used here.
  logic unused_inst_count;
  assign unused_inst_count = ^inst_count;

  state_e                  state_q, state_d;
  logic [`DBITS-1:0]       regs_q [NUM_REGS];
  logic [`DBITS-1:0]       retired_count_q;
  logic [`DBITS-1:0]       last_pc_q;

  logic valid, canary_ok, retire, commit_wr;

  assign valid     = (op_i != '0);
  assign canary_ok = (bus_canary == CANARY_VALUE);
  // Gating with reset keeps commit_wr (and therefore the bypass and the
  // forwarded commit fields) low while reset is held.
  assign retire    = reset && valid && (state_q == RUN) && canary_ok;
  assign commit_wr = retire && wr_reg && (reg_dest != '0);

  // Next-state logic; ERROR takes priority over HALTED.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (valid) begin
          if (!canary_ok)             state_d = ERROR;
          else if (inst == HALT_INST) state_d = HALTED;
        end
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= RUN;
      regs_q          <= '{default: '0};
      retired_count_q <= '0;
      last_pc_q       <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_count_q <= retired_count_q + `DBITS'(1);
        last_pc_q       <= pc;
      end
      if (commit_wr) regs_q[reg_dest] <= result;
    end
  end

  // Read ports: x0 is hard zero, then same-cycle write-through, then the array.
  always_comb begin
    rs1_val = '0;
    if (rs1_idx != '0) begin
      if (commit_wr && (reg_dest == rs1_idx)) rs1_val = result;
      else                                    rs1_val = regs_q[rs1_idx];
    end
  end

  always_comb begin
    rs2_val = '0;
    if (rs2_idx != '0) begin
      if (commit_wr && (reg_dest == rs2_idx)) rs2_val = result;
      else                                    rs2_val = regs_q[rs2_idx];
    end
  end

  assign from_WB_to_DE   = {commit_wr, reg_dest, result};
  assign from_WB_to_AGEX = {commit_wr, reg_dest};
  assign retired_count   = retired_count_q;
  assign last_pc         = last_pc_q;
  assign halted          = (state_q == HALTED);
  assign canary_err      = (state_q == ERROR);

endmodule

// File: tb/tb_wb_stage.sv
`ifndef WB_STAGE_DEFS
`define WB_STAGE_DEFS
`define DBITS 32
`define INSTBITS 32
`define OPBITS 8
`define CANARY_BITS 16
`define BUS_CANARY_VALUE 16'hCAFE
`define MEM_latch_WIDTH (`INSTBITS + `DBITS + `OPBITS + `DBITS + 5 + `DBITS + 1 + `CANARY_BITS)
`define from_WB_to_DE_WIDTH (1 + 5 + `DBITS)
`define from_WB_to_AGEX_WIDTH (1 + 5)
`endif

module tb_wb_stage;
  localparam logic [31:0] HALT = 32'h0000_0073;
  localparam logic [15:0] CV   = 16'hCAFE;

  logic                              clk = 1'b0;
  logic                              reset = 1'b0;
  logic [`MEM_latch_WIDTH-1:0]       from_MEM_latch = '0;
  logic [4:0]                        rs1_idx = '0, rs2_idx = '0;
  logic [`DBITS-1:0]                 rs1_val, rs2_val;
  logic [`from_WB_to_DE_WIDTH-1:0]   from_WB_to_DE;
  logic [`from_WB_to_AGEX_WIDTH-1:0] from_WB_to_AGEX;
  logic [`DBITS-1:0]                 retired_count, last_pc;
  logic                              halted, canary_err;

  wb_stage #(.HALT_INST(HALT), .CANARY_VALUE(CV), .NUM_REGS(32)) dut (
    .clk(clk), .reset(reset), .from_MEM_latch(from_MEM_latch),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .from_WB_to_DE(from_WB_to_DE), .from_WB_to_AGEX(from_WB_to_AGEX),
    .retired_count(retired_count), .last_pc(last_pc),
    .halted(halted), .canary_err(canary_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errs    = 0;

  // Reference model: architectural state of the writeback stage.
  logic [31:0] m_regs [32];
  logic [31:0] m_count, m_lastpc;
  int          m_mode;   // 0 running, 1 halted, 2 canary error

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_count = '0; m_lastpc = '0; m_mode = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1: drive one latch, check combinational outputs,
  // clock it, then check the registered state.
  task automatic step(input logic [31:0] inst, input logic [31:0] pc, input logic [7:0] op,
                      input logic [4:0] dest, input logic [31:0] res, input logic wr,
                      input logic [15:0] can, input logic [4:0] i1, input logic [4:0] i2);
    bit retire, cw;
    logic [31:0] e1, e2;
    from_MEM_latch = {inst, pc, op, 32'h0, dest, res, wr, can};
    rs1_idx = i1; rs2_idx = i2;
    #2;
    retire = (op != 0) && (m_mode == 0) && (can == CV);
    cw     = retire && wr && (dest != 0);
    e1 = (i1 == 0) ? 32'h0 : ((cw && dest == i1) ? res : m_regs[i1]);
    e2 = (i2 == 0) ? 32'h0 : ((cw && dest == i2) ? res : m_regs[i2]);
    chk("rs1_val", 64'(rs1_val), 64'(e1));
    chk("rs2_val", 64'(rs2_val), 64'(e2));
    chk("to_DE", 64'(from_WB_to_DE), 64'({cw, dest, res}));
    chk("to_AGEX", 64'(from_WB_to_AGEX), 64'({cw, dest}));
    @(posedge clk);
    if (m_mode == 0 && op != 0) begin
      if (can != CV) m_mode = 2;
      else begin
        m_count  = m_count + 1;
        m_lastpc = pc;
        if (wr && dest != 0) m_regs[dest] = res;
        if (inst == HALT) m_mode = 1;
      end
    end
    #1;
    chk("retired_count", 64'(retired_count), 64'(m_count));
    chk("last_pc", 64'(last_pc), 64'(m_lastpc));
    chk("halted", 64'(halted), 64'(m_mode == 1));
    chk("canary_err", 64'(canary_err), 64'(m_mode == 2));
  endtask

  // Called at posedge+1 with reset high: assert reset asynchronously while a
  // valid write sits on the latch, check outputs immediately, then release.
  task automatic do_reset();
    from_MEM_latch = {32'h13, 32'h200, 8'h1, 32'h0, 5'd9, 32'hBEEF, 1'b1, CV};
    rs1_idx = 5'd9; rs2_idx = 5'd5;
    #1 reset = 1'b0;
    m_clear();
    #1;
    chk("rst_rs1_val", 64'(rs1_val), 64'h0);
    chk("rst_rs2_val", 64'(rs2_val), 64'h0);
    chk("rst_DE_commit", 64'(from_WB_to_DE[`from_WB_to_DE_WIDTH-1]), 64'h0);
    chk("rst_AGEX_commit", 64'(from_WB_to_AGEX[`from_WB_to_AGEX_WIDTH-1]), 64'h0);
    chk("rst_count", 64'(retired_count), 64'h0);
    chk("rst_last_pc", 64'(last_pc), 64'h0);
    chk("rst_halted", 64'(halted), 64'h0);
    chk("rst_canary_err", 64'(canary_err), 64'h0);
    @(posedge clk); #1;
    chk("rst_x9_lost", 64'(rs1_val), 64'h0);
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] ri, rr;
    logic [4:0]  rd, a, b;
    m_clear();
    @(posedge clk); #1;
    reset = 1'b1;
    do_reset();

    // Basic commit, then read back next cycle.
    step(32'h0050_0293, 32'h100, 8'h1, 5'd5, 32'h1234, 1'b1, CV, 5'd5, 5'd0);
    chk("x5_after", 64'(m_regs[5]), 64'h1234);
    step(32'h13, 32'h104, 8'h0, 5'd0, 32'h0, 1'b0, 16'h0, 5'd5, 5'd5);
    // Same-cycle bypass on both ports.
    step(32'h13, 32'h108, 8'h1, 5'd7, 32'hDEAD, 1'b1, CV, 5'd7, 5'd7);
    // Write to x0 is dropped but the instruction still retires.
    step(32'h13, 32'h10C, 8'h1, 5'd0, 32'hFFFF_FFFF, 1'b1, CV, 5'd0, 5'd0);
    step(32'h13, 32'h110, 8'h0, 5'd0, 32'h0, 1'b0, 16'h0, 5'd0, 5'd7);
    // Bubbles.
    for (int i = 0; i < 10; i++)
      step('0, '0, 8'h0, 5'd0, 32'h0, 1'b0, 16'h0, 5'($urandom), 5'($urandom));

    // Randomized valid traffic, canary always good, never the halt encoding.
    for (int i = 0; i < 200; i++) begin
      ri = $urandom; if (ri == HALT) ri = 32'h13;
      rr = $urandom; rd = 5'($urandom);
      a = ($urandom_range(0, 1) == 1) ? rd : 5'($urandom);
      b = ($urandom_range(0, 1) == 1) ? a  : 5'($urandom);
      step(ri, $urandom, 8'($urandom_range(0, 3)), rd, rr, 1'($urandom), CV, a, b);
    end

    // Halt: x3 set first, halt retires, later write to x3 ignored.
    step(32'h13, 32'h3C, 8'h1, 5'd3, 32'h3333, 1'b1, CV, 5'd3, 5'd0);
    step(HALT, 32'h40, 8'h1, 5'd0, 32'h0, 1'b0, CV, 5'd3, 5'd3);
    chk("halt_last_pc", 64'(last_pc), 64'h40);
    step(32'h13, 32'h44, 8'h1, 5'd3, 32'h9999, 1'b1, CV, 5'd3, 5'd3);
    chk("x3_frozen", 64'(rs1_val), 64'h3333);

    // Back to RUN, then bad canary on a halt instruction: ERROR wins.
    do_reset();
    step(HALT, 32'h80, 8'h1, 5'd4, 32'h4444, 1'b1, CV ^ 16'h0001, 5'd4, 5'd0);
    step(32'h13, 32'h84, 8'h1, 5'd4, 32'h5555, 1'b1, CV, 5'd4, 5'd4);
    do_reset();
    step(32'h13, 32'h90, 8'h1, 5'd6, 32'h6666, 1'b1, CV, 5'd6, 5'd6);
    step(32'h13, 32'h94, 8'h0, 5'd0, 32'h0, 1'b0, 16'h0, 5'd6, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached without completing sequence");
    $fatal(1, "timeout");
  end
endmodule
